// File: rtl/alien_march_ctrl.sv
// Alien formation march sequencer: frame-paced steps, edge drops, kill speed-up, renderer req/ack.
// Optional: define ALIEN_MARCH_ANIM_EN to build the sprite animation phase toggle (anim_frame).
module alien_march_ctrl #(
    parameter logic [7:0] X_MIN       = 8'd0,
    parameter logic [7:0] X_MAX       = 8'd40,
    parameter logic [7:0] STEP        = 8'd2,
    parameter logic [7:0] DROP        = 8'd4,
    parameter logic [6:0] Y_LIMIT     = 7'd60,
    parameter logic [7:0] PERIOD_INIT = 8'd8,
    parameter logic [7:0] PERIOD_MIN  = 8'd1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       alien_killed,
    input  logic       redraw_ack,
    output logic [7:0] x_off,
    output logic [6:0] y_off,
    output logic       dir,
    output logic       step_pulse,
    output logic       redraw_req,
    output logic       hit_bottom,
    output logic       anim_frame
);

    typedef enum logic [1:0] {S_WAIT, S_MOVE, S_REDRAW, S_HALT} state_t;

    state_t     state;
    logic [7:0] period;
    logic [7:0] count;
    logic [8:0] x_right;
    logic [7:0] y_drop;
    logic       at_edge;

    assign x_right = {1'b0, x_off} + {1'b0, STEP};
    assign y_drop  = {1'b0, y_off} + DROP;
    assign at_edge = dir ? (x_right > {1'b0, X_MAX})
                         : ({1'b0, x_off} < ({1'b0, X_MIN} + {1'b0, STEP}));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_WAIT;
            x_off      <= X_MIN;
            y_off      <= 7'd0;
            dir        <= 1'b1;
            period     <= PERIOD_INIT;
            count      <= 8'd0;
            step_pulse <= 1'b0;
            redraw_req <= 1'b0;
            hit_bottom <= 1'b0;
`ifdef ALIEN_MARCH_ANIM_EN
            anim_frame <= 1'b0;
`endif
        end else begin
            step_pulse <= 1'b0;
            if (alien_killed)
                period <= (period > PERIOD_MIN) ? period - 8'd1 : PERIOD_MIN;

            case (state)
                S_WAIT: begin
                    // >= so a period shortened mid-interval ends it at once instead of wrapping
                    if (frame_tick && enable) begin
                        if (count >= period - 8'd1) begin
                            count <= 8'd0;
                            state <= S_MOVE;
                        end else begin
                            count <= count + 8'd1;
                        end
                    end
                end
                S_MOVE: begin
                    step_pulse <= 1'b1;
                    redraw_req <= 1'b1;
`ifdef ALIEN_MARCH_ANIM_EN
                    anim_frame <= ~anim_frame;
`endif
                    if (!at_edge) begin
                        x_off <= dir ? x_right[7:0] : x_off - STEP;
                        state <= S_REDRAW;
                    end else begin
                        dir <= ~dir;
                        if (y_drop >= {1'b0, Y_LIMIT}) begin
                            y_off      <= Y_LIMIT;
                            hit_bottom <= 1'b1;
                            state      <= S_HALT;
                        end else begin
                            y_off <= y_drop[6:0];
                            state <= S_REDRAW;
                        end
                    end
                end
                S_REDRAW: begin
                    if (redraw_ack) begin
                        redraw_req <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_HALT: begin
                    if (redraw_ack)
                        redraw_req <= 1'b0;
                end
                default: state <= S_WAIT;
            endcase
        end
    end

`ifndef ALIEN_MARCH_ANIM_EN
    assign anim_frame = 1'b0;
`endif

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Self-checking bench for alien_march_ctrl: directed scenarios plus randomized stimulus
// compared every cycle against a rule-level march model.
module tb_alien_march_ctrl;

    localparam int XMIN = 0, XMAX = 40, STEP = 2, DROP = 4, YLIM = 60;
    localparam int PINIT = 8, PMIN = 1;
`ifdef ALIEN_MARCH_ANIM_EN
    localparam bit ANIM = 1'b1;
`else
    localparam bit ANIM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       enable = 1'b0;
    logic       alien_killed = 1'b0;
    logic       redraw_ack = 1'b0;
    logic [7:0] x_off;
    logic [6:0] y_off;
    logic       dir, step_pulse, redraw_req, hit_bottom, anim_frame;

    int n_cmp = 0;
    int n_err = 0;

    // model of the march: position, heading, speed and handshake status
    int m_x, m_y, m_per, m_cnt;
    bit m_dir, m_pulse, m_req, m_hit, m_anim, m_move_next, m_halt;

    alien_march_ctrl dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .enable(enable),
        .alien_killed(alien_killed), .redraw_ack(redraw_ack), .x_off(x_off), .y_off(y_off),
        .dir(dir), .step_pulse(step_pulse), .redraw_req(redraw_req),
        .hit_bottom(hit_bottom), .anim_frame(anim_frame)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] dut_v();
        return {x_off, y_off, dir, step_pulse, redraw_req, hit_bottom, anim_frame};
    endfunction

    function automatic logic [19:0] model_v();
        logic [7:0] mx;
        logic [6:0] my;
        mx = m_x[7:0];
        my = m_y[6:0];
        return {mx, my, m_dir, m_pulse, m_req, m_hit, m_anim};
    endfunction

    function automatic logic [19:0] reset_v();
        logic [7:0] rx;
        rx = XMIN[7:0];
        return {rx, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction

    task automatic model_reset();
        m_x = XMIN; m_y = 0; m_dir = 1'b1; m_per = PINIT; m_cnt = 0;
        m_pulse = 1'b0; m_req = 1'b0; m_hit = 1'b0; m_anim = 1'b0;
        m_move_next = 1'b0; m_halt = 1'b0;
    endtask

    // one clock: drive inputs, advance the model on the edge, settle 1 time unit
    task automatic cyc(input bit ft, input bit en, input bit kill, input bit ack, input bit rn);
        int old_per;
        frame_tick = ft; enable = en; alien_killed = kill; redraw_ack = ack; reset_n = rn;
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            old_per = m_per;
            m_pulse = 1'b0;
            if (kill) m_per = (m_per - 1 < PMIN) ? PMIN : m_per - 1;
            if (m_move_next) begin
                m_move_next = 1'b0;
                if (m_dir && m_x + STEP <= XMAX) m_x = m_x + STEP;
                else if (!m_dir && m_x >= XMIN + STEP) m_x = m_x - STEP;
                else begin
                    m_dir = !m_dir;
                    if (m_y + DROP >= YLIM) begin
                        m_y = YLIM; m_hit = 1'b1; m_halt = 1'b1;
                    end else begin
                        m_y = m_y + DROP;
                    end
                end
                m_pulse = 1'b1;
                m_req = 1'b1;
                if (ANIM) m_anim = !m_anim;
            end else if (m_req) begin
                if (ack) m_req = 1'b0;
            end else if (!m_halt && ft && en) begin
                if (m_cnt + 1 >= old_per) begin
                    m_cnt = 0; m_move_next = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (dut_v() !== reset_v()) begin
                n_err++;
                $display("FAIL reset_state: dut {x,y,dir,pulse,req,hit,anim}=%h required %h", dut_v(), reset_v());
            end
        end
    endtask

    task automatic test_basic_step();
        int pulses = 0, req_cycles = 0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            for (int ph = 0; ph < 2; ph++) begin
                cyc(ph == 0 && i < 8, 1'b1, 1'b0, 1'b1, 1'b1);
                pulses += step_pulse;
                req_cycles += redraw_req;
                n_cmp++;
                if (dut_v() !== model_v()) begin
                    n_err++;
                    $display("FAIL basic_step: dut=%h model=%h", dut_v(), model_v());
                end
                if (i == 7) begin
                    n_cmp++;
                    if (x_off !== (ph == 0 ? 8'd0 : 8'd2)) begin
                        n_err++;
                        $display("FAIL basic_latency: x_off=%0d required %0d", x_off, (ph == 0 ? 0 : 2));
                    end
                end
            end
        end
        n_cmp++;
        if (pulses != 1 || req_cycles != 1 || dir !== 1'b1) begin
            n_err++;
            $display("FAIL basic_pulse: pulses=%0d req_cycles=%0d dir=%b required 1 1 1", pulses, req_cycles, dir);
        end
    endtask

    task automatic test_right_edge();
        int budget = 0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (m_dir && budget < 1000) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            budget++;
            n_cmp++;
            if (dut_v() !== model_v()) begin
                n_err++;
                $display("FAIL right_edge: dut=%h model=%h", dut_v(), model_v());
            end
        end
        n_cmp++;
        if (x_off !== 8'd40 || y_off !== 7'd4 || dir !== 1'b0 || budget >= 1000) begin
            n_err++;
            $display("FAIL edge_drop: x=%0d y=%0d dir=%b required 40 4 0", x_off, y_off, dir);
        end
        budget = 0;
        do begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            budget++;
        end while (!step_pulse && budget < 50);
        n_cmp++;
        if (x_off !== 8'd38 || y_off !== 7'd4) begin
            n_err++;
            $display("FAIL edge_reverse: x=%0d y=%0d required 38 4", x_off, y_off);
        end
    endtask

    task automatic test_speedup();
        int pulses = 0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 30; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            pulses += step_pulse;
            n_cmp++;
            if (dut_v() !== model_v()) begin
                n_err++;
                $display("FAIL speedup: dut=%h model=%h", dut_v(), model_v());
            end
        end
        n_cmp++;
        if (pulses != 10) begin
            n_err++;
            $display("FAIL speedup_rate: steps=%0d required 10", pulses);
        end
    endtask

    task automatic test_handshake();
        int k = 0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            k++;
        end while (!step_pulse && k < 20);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (redraw_req !== 1'b1 || x_off !== 8'd2 || dut_v() !== model_v()) begin
                n_err++;
                $display("FAIL handshake_hold: req=%b x=%0d required 1 2 (dut=%h model=%h)", redraw_req, x_off, dut_v(), model_v());
            end
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (redraw_req !== 1'b0) begin
            n_err++;
            $display("FAIL handshake_ack: req=%b required 0", redraw_req);
        end
        k = 0;
        do begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            k++;
        end while (!step_pulse && k < 30);
        n_cmp++;
        if (k != 9 || x_off !== 8'd4) begin
            n_err++;
            $display("FAIL handshake_next: pulse on cycle %0d x=%0d required 9 4", k, x_off);
        end
    endtask

    task automatic test_bottom();
        int budget = 0;
        logic [7:0] hx;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        while (!m_hit && budget < 3000) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            budget++;
            n_cmp++;
            if (dut_v() !== model_v()) begin
                n_err++;
                $display("FAIL bottom_march: dut=%h model=%h", dut_v(), model_v());
            end
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (y_off !== 7'd60 || hit_bottom !== 1'b1 || budget >= 3000) begin
            n_err++;
            $display("FAIL bottom_hit: y=%0d hit=%b required 60 1", y_off, hit_bottom);
        end
        hx = x_off;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            n_cmp++;
            if (x_off !== hx || y_off !== 7'd60 || hit_bottom !== 1'b1 || step_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL bottom_frozen: x=%0d y=%0d hit=%b pulse=%b required %0d 60 1 0", x_off, y_off, hit_bottom, step_pulse, hx);
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (dut_v() !== reset_v()) begin
            n_err++;
            $display("FAIL bottom_reset: dut=%h required %h", dut_v(), reset_v());
        end
        budget = 0;
        do begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            budget++;
        end while (!redraw_req && budget < 20);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (redraw_req !== 1'b0 || dut_v() !== reset_v()) begin
            n_err++;
            $display("FAIL reset_in_redraw: req=%b dut=%h required 0 %h", redraw_req, dut_v(), reset_v());
        end
    endtask

    task automatic test_random();
        bit ft, en, kill, ack, rn;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            ft   = ($urandom_range(0, 2) == 0);
            en   = ($urandom_range(0, 7) != 0);
            kill = ($urandom_range(0, 19) == 0);
            ack  = ($urandom_range(0, 1) == 0);
            rn   = ($urandom_range(0, 399) != 0);
            cyc(ft, en, kill, ack, rn);
            n_cmp++;
            if (dut_v() !== model_v()) begin
                n_err++;
                $display("FAIL random cycle %0d: dut=%h model=%h", i, dut_v(), model_v());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_step();
        test_right_edge();
        test_speedup();
        test_handshake();
        test_bottom();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
